// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped branch target buffer with 2-bit direction counters
//
// Purpose:
//   IF-stage branch target buffer. Each entry holds a valid bit, a tag, a
//   target address and a 2-bit saturating direction counter. The lookup is
//   combinational from registered state. The ID stage reports resolved
//   branches through the update port. A saturating counter accumulates
//   mispredicted updates.
//
// Ports:
//   clk            in   clock, all state changes on the rising edge
//   reset          in   synchronous active-low reset
//   lk_pc          in   IF-stage PC to look up
//   lk_hit         out  valid entry with matching tag at the lk_pc index
//   lk_taken       out  lk_hit and counter MSB set
//   lk_target      out  stored target when lk_taken, else lk_pc + 4
//   upd_valid      in   a resolved branch is reported this cycle
//   upd_pc         in   PC of the resolved branch
//   upd_taken      in   actual outcome
//   upd_target     in   actual target
//   upd_pred_taken in   prediction that was issued for this branch
//   flush          in   invalidate every entry
//   mispredict_cnt out  saturating count of mispredicted updates

module branch_target_predictor #(
  parameter int          ENTRIES  = 16,
  parameter int          ADDR_W   = 32,
  parameter int          CNT_W    = 16,
  parameter logic [1:0]  INIT_CTR = 2'b01
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              lk_hit,
  output logic              lk_taken,
  output logic [ADDR_W-1:0] lk_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic              flush,
  output logic [CNT_W-1:0]  mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  // Counter value given to an entry allocated by a taken branch: weakly taken.
  localparam logic [1:0] ALLOC_CTR = 2'b10;

  logic              r_valid  [ENTRIES];
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  logic [ADDR_W-1:0] r_target [ENTRIES];
  logic [1:0]        r_ctr    [ENTRIES];
  logic [CNT_W-1:0]  r_mis_cnt;

  // Lookup path
  logic [IDX_W-1:0]  w_lk_idx;
  logic [TAG_W-1:0]  w_lk_tag;
  logic              w_lk_hit;
  logic              w_lk_taken;

  assign w_lk_idx   = lk_pc[IDX_W+1:2];
  assign w_lk_tag   = lk_pc[ADDR_W-1:IDX_W+2];
  assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_lk_taken = w_lk_hit && r_ctr[w_lk_idx][1];

  assign lk_hit    = w_lk_hit;
  assign lk_taken  = w_lk_taken;
  assign lk_target = w_lk_taken ? r_target[w_lk_idx] : (lk_pc + ADDR_W'(4));

  // Update path
  logic [IDX_W-1:0]  w_upd_idx;
  logic [TAG_W-1:0]  w_upd_tag;
  logic              w_upd_hit;
  logic [1:0]        w_upd_ctr_cur;
  logic [1:0]        w_upd_ctr_inc;
  logic [1:0]        w_upd_ctr_dec;
  logic              w_mispredict;

  assign w_upd_idx     = upd_pc[IDX_W+1:2];
  assign w_upd_tag     = upd_pc[ADDR_W-1:IDX_W+2];
  assign w_upd_hit     = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  assign w_upd_ctr_cur = r_ctr[w_upd_idx];
  assign w_upd_ctr_inc = (w_upd_ctr_cur == 2'b11) ? 2'b11 : (w_upd_ctr_cur + 2'd1);
  assign w_upd_ctr_dec = (w_upd_ctr_cur == 2'b00) ? 2'b00 : (w_upd_ctr_cur - 2'd1);
  assign w_mispredict  = upd_valid && (upd_pred_taken != upd_taken);

  // Byte-offset PC bits and the reserved not-taken init value are not used.
  logic w_unused;
  assign w_unused = ^{INIT_CTR, lk_pc[1:0], upd_pc[1:0]};

  // Entry state. Tags and targets carry no reset: they are only meaningful
  // while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b00;
      end
    end else if (flush) begin
      // A same-cycle update is dropped; the flush wins.
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
      end
    end else if (upd_valid) begin
      if (w_upd_hit) begin
        if (upd_taken) begin
          r_ctr[w_upd_idx]    <= w_upd_ctr_inc;
          r_target[w_upd_idx] <= upd_target;
        end else begin
          r_ctr[w_upd_idx]    <= w_upd_ctr_dec;
        end
      end else if (upd_taken) begin
        // Miss on a taken branch overwrites whatever occupies the slot.
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= upd_target;
        r_ctr[w_upd_idx]    <= ALLOC_CTR;
      end
    end
  end

  // Mispredict statistics. Counted even when a flush drops the update,
  // because the resolved outcome is still real.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mis_cnt <= '0;
    end else if (w_mispredict && (r_mis_cnt != {CNT_W{1'b1}})) begin
      r_mis_cnt <= r_mis_cnt + CNT_W'(1);
    end
  end

  assign mispredict_cnt = r_mis_cnt;

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb/tb_branch_target_predictor.sv - directed vector bench for branch_target_predictor
//
// Purpose:
//   Table of per-cycle vectors (inputs plus the outputs expected before the
//   edge that applies them), followed by hand-written sequences for counter
//   saturation and reset during traffic.
//
// Ports: none (top-level bench).

module tb_branch_target_predictor;

  localparam int ENTRIES = 16;
  localparam int ADDR_W  = 32;
  localparam int CNT_W   = 4;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] lk_pc;
  logic              lk_hit;
  logic              lk_taken;
  logic [ADDR_W-1:0] lk_target;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_pred_taken;
  logic              flush;
  logic [CNT_W-1:0]  mispredict_cnt;

  int checks   = 0;
  int failures = 0;

  branch_target_predictor #(
    .ENTRIES (ENTRIES),
    .ADDR_W  (ADDR_W),
    .CNT_W   (CNT_W),
    .INIT_CTR(2'b01)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .lk_pc          (lk_pc),
    .lk_hit         (lk_hit),
    .lk_taken       (lk_taken),
    .lk_target      (lk_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .flush          (flush),
    .mispredict_cnt (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        flush;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred;
    logic [31:0] lk_pc;
    logic        exp_hit;
    logic        exp_taken;
    logic [31:0] exp_target;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic fl, logic uv, logic [31:0] upc,
                              logic ut, logic [31:0] utgt, logic up, logic [31:0] lpc,
                              logic eh, logic et, logic [31:0] etgt, logic [3:0] ec);
    vec_t v;
    v.name = name; v.flush = fl; v.upd_valid = uv; v.upd_pc = upc;
    v.upd_taken = ut; v.upd_target = utgt; v.upd_pred = up; v.lk_pc = lpc;
    v.exp_hit = eh; v.exp_taken = et; v.exp_target = etgt; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(string name, logic eh, logic et, logic [31:0] etgt, logic [3:0] ec);
    check({name, ".hit"},    {31'd0, lk_hit},   {31'd0, eh});
    check({name, ".taken"},  {31'd0, lk_taken}, {31'd0, et});
    check({name, ".target"}, lk_target,         etgt);
    check({name, ".cnt"},    {28'd0, mispredict_cnt}, {28'd0, ec});
  endtask

  task automatic idle_inputs();
    flush = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_pred_taken = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    lk_pc = 32'h40;
    idle_inputs();

    // Each vector's expectations describe the lookup before its own edge.
    //             name          fl uv upd_pc        ut upd_tgt       up lk_pc         hit tk target        cnt
    vecs.push_back(mk("rst_look",   0, 0, 32'h0,        0, 32'h0,      0, 32'h40,       0, 0, 32'h44,       4'd0));
    vecs.push_back(mk("alloc_same", 0, 1, 32'h40,       1, 32'h100,    0, 32'h40,       0, 0, 32'h44,       4'd0));
    vecs.push_back(mk("alloc_hit",  0, 0, 32'h0,        0, 32'h0,      0, 32'h40,       1, 1, 32'h100,      4'd1));
    vecs.push_back(mk("nt1",        0, 1, 32'h40,       0, 32'h0,      1, 32'h40,       1, 1, 32'h100,      4'd1));
    vecs.push_back(mk("nt2",        0, 1, 32'h40,       0, 32'h0,      0, 32'h40,       1, 0, 32'h44,       4'd2));
    vecs.push_back(mk("tk1",        0, 1, 32'h40,       1, 32'h100,    0, 32'h40,       1, 0, 32'h44,       4'd2));
    vecs.push_back(mk("tk2",        0, 1, 32'h40,       1, 32'h104,    0, 32'h40,       1, 0, 32'h44,       4'd3));
    vecs.push_back(mk("tk3",        0, 1, 32'h40,       1, 32'h100,    1, 32'h40,       1, 1, 32'h104,      4'd4));
    vecs.push_back(mk("tk_sat",     0, 1, 32'h40,       1, 32'h100,    1, 32'h40,       1, 1, 32'h100,      4'd4));
    vecs.push_back(mk("dec_from3",  0, 1, 32'h40,       0, 32'h0,      1, 32'h40,       1, 1, 32'h100,      4'd4));
    vecs.push_back(mk("still_tk",   0, 0, 32'h0,        0, 32'h0,      0, 32'h40,       1, 1, 32'h100,      4'd5));
    vecs.push_back(mk("alias_upd",  0, 1, 32'h80,       1, 32'h200,    1, 32'h40,       1, 1, 32'h100,      4'd5));
    vecs.push_back(mk("alias_old",  0, 0, 32'h0,        0, 32'h0,      0, 32'h40,       0, 0, 32'h44,       4'd5));
    vecs.push_back(mk("alias_new",  0, 0, 32'h0,        0, 32'h0,      0, 32'h80,       1, 1, 32'h200,      4'd5));
    vecs.push_back(mk("alloc48",    0, 1, 32'h48,       1, 32'h300,    1, 32'h48,       0, 0, 32'h4C,       4'd5));
    vecs.push_back(mk("hit48",      0, 0, 32'h0,        0, 32'h0,      0, 32'h48,       1, 1, 32'h300,      4'd5));
    vecs.push_back(mk("flush_upd",  1, 1, 32'h48,       1, 32'h400,    0, 32'h80,       1, 1, 32'h200,      4'd5));
    vecs.push_back(mk("fl_48",      0, 0, 32'h0,        0, 32'h0,      0, 32'h48,       0, 0, 32'h4C,       4'd6));
    vecs.push_back(mk("fl_80",      0, 0, 32'h0,        0, 32'h0,      0, 32'h80,       0, 0, 32'h84,       4'd6));
    vecs.push_back(mk("fl_40",      0, 0, 32'h0,        0, 32'h0,      0, 32'h40,       0, 0, 32'h44,       4'd6));
    vecs.push_back(mk("wrap",       0, 0, 32'h0,        0, 32'h0,      0, 32'hFFFF_FFFC,0, 0, 32'h0,        4'd6));
    vecs.push_back(mk("lowbits",    0, 1, 32'h4E,       1, 32'h500,    1, 32'h4C,       0, 0, 32'h50,       4'd6));
    vecs.push_back(mk("lowbits_hit",0, 0, 32'h0,        0, 32'h0,      0, 32'h4D,       1, 1, 32'h500,      4'd6));
    vecs.push_back(mk("nt_miss",    0, 1, 32'h1000,     0, 32'h600,    0, 32'h4C,       1, 1, 32'h500,      4'd6));
    vecs.push_back(mk("no_alloc",   0, 0, 32'h0,        0, 32'h0,      0, 32'h1000,     0, 0, 32'h1004,     4'd6));

    repeat (2) @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      flush          = vecs[i].flush;
      upd_valid      = vecs[i].upd_valid;
      upd_pc         = vecs[i].upd_pc;
      upd_taken      = vecs[i].upd_taken;
      upd_target     = vecs[i].upd_target;
      upd_pred_taken = vecs[i].upd_pred;
      lk_pc          = vecs[i].lk_pc;
      #1;
      check_outputs(vecs[i].name, vecs[i].exp_hit, vecs[i].exp_taken,
                    vecs[i].exp_target, vecs[i].exp_cnt);
    end

    // Unknown update fields with upd_valid low must leave state alone.
    @(negedge clk);
    idle_inputs();
    upd_pc = 'x; upd_target = 'x; upd_taken = 1'bx; upd_pred_taken = 1'bx;
    lk_pc = 32'h4C;
    @(negedge clk);
    idle_inputs();
    #1;
    check_outputs("x_idle", 1'b1, 1'b1, 32'h500, 4'd6);

    // Twenty mispredicted not-taken updates: counter pins at 15.
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      upd_valid = 1'b1; upd_pc = 32'h2000; upd_taken = 1'b0; upd_pred_taken = 1'b1;
      if (n == 10) begin
        #1;
        check("sat_mid.cnt", {28'd0, mispredict_cnt}, 32'd15);
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    check("sat_end.cnt", {28'd0, mispredict_cnt}, 32'd15);

    // Reset for one cycle while a taken update is presented.
    @(negedge clk);
    reset = 1'b0;
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1;
    upd_target = 32'h700; upd_pred_taken = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    lk_pc = 32'h40;
    #1;
    check_outputs("rst2_40", 1'b0, 1'b0, 32'h44, 4'd0);
    lk_pc = 32'h4C;
    #1;
    check_outputs("rst2_4C", 1'b0, 1'b0, 32'h50, 4'd0);
    lk_pc = 32'h80;
    #1;
    check_outputs("rst2_80", 1'b0, 1'b0, 32'h84, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Parametrised branch target buffer (BTB) with 2-bit saturating direction counters.
- Sits in the IF stage of the 5-stage core, beside the PC adder, and supplies a predicted next PC so a taken branch no longer costs an IF/ID flush when the prediction is correct.
- The ID-stage branch comparator resolves each branch and reports the outcome back through the update port.
- Also keeps a saturating mispredict counter for performance measurement.

Parameters:
ENTRIES, 16, number of BTB entries; must be a power of 2 and at least 2
ADDR_W, 32, PC and target width in bits
CNT_W, 16, width of the mispredict statistics counter
INIT_CTR, 2'b01, counter value for newly allocated not-taken entries (reserved; allocation currently only on taken)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-low reset
lk_pc  input  ADDR_W  IF-stage PC to look up
lk_hit  output  1  a valid entry matches lk_pc
lk_taken  output  1  predict taken (lk_hit and counter bit 1 set)
lk_target  output  ADDR_W  predicted target; equals stored target when lk_taken, else lk_pc+4
upd_valid  input  1  ID stage has resolved a branch this cycle
upd_pc  input  ADDR_W  PC of the resolved branch
upd_taken  input  1  actual branch outcome
upd_target  input  ADDR_W  actual branch target address
upd_pred_taken  input  1  prediction that was issued for this branch
flush  input  1  invalidate all entries
mispredict_cnt  output  CNT_W  saturating count of mispredicted updates

Behaviour:
- IDX_W = log2(ENTRIES).
- Index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]. pc[1:0] are ignored.
- Each entry holds: valid (1 bit), tag, target (ADDR_W bits), ctr (2 bits).
- Lookup path:
  - Purely combinational from registered entry state; zero-cycle latency.
  - Reads pre-edge state: no write-to-read bypass, so an update and lookup to the same index in one cycle return the old entry.
  - lk_target = lk_taken ? stored target : lk_pc + 4, with modulo 2^ADDR_W wrap.
- Update, when upd_valid=1 and the entry at the upd_pc index:
  - Hits (valid and tag equal):
    - Taken: ctr = min(ctr+1, 3) and target = upd_target.
    - Not taken: ctr = max(ctr-1, 0); target unchanged.
  - Misses, outcome taken: allocate (overwrite) — valid=1, tag=upd_pc tag, target=upd_target, ctr=2'b10.
  - Misses, outcome not taken: no change; no allocation.
- Mispredict counting:
  - When upd_valid=1 and upd_pred_taken != upd_taken, mispredict_cnt increments by 1.
  - Saturates at 2^CNT_W-1; never wraps.
- Flush:
  - flush=1 clears every valid bit at the next edge; tags, targets and counters are don't-care.
  - If upd_valid=1 in the same cycle, the update is dropped (flush wins).
  - mispredict_cnt still counts that update, since the outcome is real.
- Reset:
  - reset=0 at an edge clears all valid bits, all ctr to 0, and mispredict_cnt to 0.
  - Reset overrides flush and update, including mid-stream; the cycle after release starts with an empty BTB.
- Priority: reset > flush > update.
- Outputs after reset: lk_hit=0, lk_taken=0, lk_target=lk_pc+4, mispredict_cnt=0.
- Unknown inputs must not corrupt state while upd_valid=0 and flush=0.

Test Plan (ENTRIES=16, ADDR_W=32, CNT_W=4):
1. Reset low 2 cycles, then lk_pc=0x40 -> lk_hit=0, lk_taken=0, lk_target=0x44, mispredict_cnt=0.
2. Update pc=0x40, taken=1, target=0x100, pred=0; next cycle lk_pc=0x40 -> lk_hit=1, lk_taken=1, lk_target=0x100, mispredict_cnt=1. Same-cycle lookup of 0x40 during the update -> lk_hit=0.
3. Starting from ctr=2'b10 at pc=0x40, apply 2 not-taken updates -> after the first, lk_taken=0 and lk_hit=1 (ctr=01); after the second, ctr=00. Then apply 3 taken updates -> ctr saturates at 11; a further taken update leaves 11.
4. Aliasing: with pc=0x40 allocated, update pc=0x80 (same index 0, different tag) taken, target 0x200 -> lookup 0x40 gives lk_hit=0; lookup 0x80 gives lk_target=0x200.
5. Assert flush and a taken update (pc=0x48) in the same cycle -> next cycle lookups of 0x40 and 0x48 both give lk_hit=0; mispredict_cnt still counts that update if pred differed.
6. Issue 20 mispredicted updates -> mispredict_cnt stops at 15. Then reset=0 for 1 cycle -> mispredict_cnt=0 and all lookups miss.
